uart_axil_fifo: RTL and testbench

AXI4-Lite UART transmit slave, the parametrised successor of the single-register print stub. Adds a TX byte FIFO of configurable depth, a live read channel (status and control registers), error responses, and a FIFO flush control. Sits on the core's MMIO AXI-Lite crossbar. Its byte output drives the simulation console sink, or a serialiser in a later revision.

---
 rtl/uart_axil_fifo.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_axil_fifo.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axil_fifo.sv
// AXI4-Lite UART transmit slave with a TX byte FIFO, status/control
// registers, error responses and a FIFO flush control.
module uart_axil_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [31:0] ARADDR,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] AWADDR,
    input  logic        WVALID,
    output logic        WREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [1:0]  BRESP,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_WAIT_ADDR = 2'd1;
    localparam logic [1:0] W_WAIT_DATA = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] A_TXDATA = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h4;
    localparam logic [3:0] A_CTRL   = 4'h8;

    logic [1:0]       wstate_q, wstate_d;
    logic [3:0]       awaddr_q, awaddr_d;
    logic [7:0]       wbyte_q, wbyte_d;
    logic             wstrb0_q, wstrb0_d;
    logic [1:0]       bresp_q, bresp_d;

    logic [0:0]       rstate_q, rstate_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic             commit;
    logic [3:0]       c_addr;
    logic [7:0]       c_byte;
    logic             c_strb0;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             flush;
    logic [31:0]      status;

    logic unused_bits;
    assign unused_bits = ^{AWADDR[31:4], ARADDR[31:4], WDATA[31:8], WSTRB[3:1]};

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && tx_ready;

    assign status = {16'h0, 8'(count_q), 6'h0, full, empty};

    assign AWREADY = (wstate_q == W_IDLE) || (wstate_q == W_WAIT_ADDR);
    assign WREADY  = (wstate_q == W_IDLE) || (wstate_q == W_WAIT_DATA);
    assign BVALID  = (wstate_q == W_RESP);
    assign BRESP   = bresp_q;

    assign ARREADY = (rstate_q == R_IDLE);
    assign RVALID  = (rstate_q == R_RESP);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign tx_valid = !empty;
    assign tx_byte  = mem_q[rd_ptr_q];

    // Write FSM: buffer each half on its own handshake, commit on the second.
    always_comb begin
        wstate_d = wstate_q;
        awaddr_d = awaddr_q;
        wbyte_d  = wbyte_q;
        wstrb0_d = wstrb0_q;
        bresp_d  = bresp_q;
        commit   = 1'b0;
        c_addr   = awaddr_q;
        c_byte   = wbyte_q;
        c_strb0  = wstrb0_q;
        case (wstate_q)
            W_IDLE: begin
                if (AWVALID && WVALID) begin
                    commit   = 1'b1;
                    c_addr   = AWADDR[3:0];
                    c_byte   = WDATA[7:0];
                    c_strb0  = WSTRB[0];
                    wstate_d = W_RESP;
                end else if (AWVALID) begin
                    awaddr_d = AWADDR[3:0];
                    wstate_d = W_WAIT_DATA;
                end else if (WVALID) begin
                    wbyte_d  = WDATA[7:0];
                    wstrb0_d = WSTRB[0];
                    wstate_d = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                if (WVALID) begin
                    commit   = 1'b1;
                    c_byte   = WDATA[7:0];
                    c_strb0  = WSTRB[0];
                    wstate_d = W_RESP;
                end
            end
            W_WAIT_ADDR: begin
                if (AWVALID) begin
                    commit   = 1'b1;
                    c_addr   = AWADDR[3:0];
                    wstate_d = W_RESP;
                end
            end
            default: begin
                if (BREADY) wstate_d = W_IDLE;
            end
        endcase
        push  = commit && (c_addr == A_TXDATA) && c_strb0 && !full;
        flush = commit && (c_addr == A_CTRL) && c_strb0 && c_byte[0];
        if (commit) begin
            if (c_addr == A_TXDATA)
                bresp_d = (c_strb0 && full) ? RESP_SLVERR : RESP_OKAY;
            else if (c_addr == A_CTRL)
                bresp_d = RESP_OKAY;
            else
                bresp_d = RESP_SLVERR;
        end
    end

    // Read FSM: snapshot the addressed register at the accept edge.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rstate_q == R_IDLE) begin
            if (ARVALID) begin
                rstate_d = R_RESP;
                case (ARADDR[3:0])
                    A_STATUS: begin
                        rdata_d = status;
                        rresp_d = RESP_OKAY;
                    end
                    A_CTRL: begin
                        rdata_d = '0;
                        rresp_d = RESP_OKAY;
                    end
                    default: begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                endcase
            end
        end else if (RREADY) begin
            rstate_d = R_IDLE;
        end
    end

    // FIFO pointers and occupancy; flush overrides any same-cycle pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            awaddr_q <= '0;
            wbyte_q  <= '0;
            wstrb0_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rstate_q <= R_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wstate_q <= wstate_d;
            awaddr_q <= awaddr_d;
            wbyte_q  <= wbyte_d;
            wstrb0_q <= wstrb0_d;
            bresp_q  <= bresp_d;
            rstate_q <= rstate_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= c_byte;
    end

endmodule

// File: tb/tb_uart_axil_fifo.sv
// Randomized bench for uart_axil_fifo against a queue-based model.
// Directed scenarios first, then mixed random read/write traffic.
module tb_uart_axil_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] ARADDR, RDATA;
    logic [1:0]  RRESP;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [31:0] AWADDR, WDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_byte;

    int n_cmp = 0;
    int n_bad = 0;
    bit rnd_rdy = 1'b0;

    uart_axil_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: transmit queue plus pending-transaction bookkeeping.
    logic [7:0]  q[$];
    bit          aw_hs, w_hs, b_pend, r_pend;
    logic [3:0]  aw_a;
    logic [7:0]  w_d;
    logic        w_s;
    logic [1:0]  exp_b, exp_rr;
    logic [31:0] exp_rd;

    always @(posedge clk) begin
        int  sz;
        bit  pop, do_push, do_flush;
        if (rst) begin
            q.delete();
            aw_hs  = 0;
            w_hs   = 0;
            b_pend = 0;
            r_pend = 0;
        end else begin
            sz = q.size();
            check("tx_valid", tx_valid, sz != 0);
            if (sz != 0) check("tx_byte", tx_byte, q[0]);
            pop = (sz != 0) && tx_ready;
            if (BVALID && BREADY) begin
                check("b_expected", b_pend, 1);
                check("bresp", BRESP, exp_b);
                b_pend = 0;
            end
            if (RVALID && RREADY) begin
                check("r_expected", r_pend, 1);
                check("rdata", RDATA, exp_rd);
                check("rresp", RRESP, exp_rr);
                r_pend = 0;
            end
            if (ARVALID && ARREADY) begin
                r_pend = 1;
                case (ARADDR[3:0])
                    4'h4: begin
                        exp_rd = {16'h0, 8'(sz), 6'h0, sz == DEPTH, sz == 0};
                        exp_rr = 2'b00;
                    end
                    4'h8: begin
                        exp_rd = 0;
                        exp_rr = 2'b00;
                    end
                    default: begin
                        exp_rd = 0;
                        exp_rr = 2'b10;
                    end
                endcase
            end
            if (AWVALID && AWREADY) begin
                aw_a  = AWADDR[3:0];
                aw_hs = 1;
            end
            if (WVALID && WREADY) begin
                w_d  = WDATA[7:0];
                w_s  = WSTRB[0];
                w_hs = 1;
            end
            do_push  = 0;
            do_flush = 0;
            if (aw_hs && w_hs) begin
                aw_hs  = 0;
                w_hs   = 0;
                b_pend = 1;
                if (aw_a == 4'h0) begin
                    if (w_s && sz == DEPTH) exp_b = 2'b10;
                    else begin
                        exp_b   = 2'b00;
                        do_push = w_s;
                    end
                end else if (aw_a == 4'h8) begin
                    exp_b    = 2'b00;
                    do_flush = w_s && w_d[0];
                end else begin
                    exp_b = 2'b10;
                end
            end
            if (do_flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (do_push) q.push_back(w_d);
            end
        end
    end

    // Random sink back-pressure during the random phase.
    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            tx_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int aw_lag,
                             input int w_lag, input int b_hold,
                             input bit pulse_rdy, output logic [1:0] resp);
        bit aw_done, w_done, hs_aw, hs_w, hs_b, got;
        int bc, cc;
        logic [1:0] r;
        aw_done = 0;
        w_done  = 0;
        got     = 0;
        bc      = 0;
        cc      = -1;
        resp    = 2'b11;
        for (int c = 0; c < 64 && !got; c++) begin
            AWADDR  = a;
            WDATA   = d;
            WSTRB   = s;
            AWVALID = !aw_done && c >= aw_lag;
            WVALID  = !w_done && c >= w_lag;
            BREADY  = BVALID && bc >= b_hold;
            if (pulse_rdy) tx_ready = (c == 0);
            #1;
            if (aw_done && w_done) begin
                check("awready_resp", AWREADY, 0);
                check("wready_resp", WREADY, 0);
                if (BVALID && bc == 0) check("b_latency", c - cc, 1);
                if (bc > 0) check("bvalid_hold", BVALID, 1);
            end else begin
                check("bvalid_early", BVALID, 0);
                check("awready", AWREADY, !aw_done);
                check("wready", WREADY, !w_done);
            end
            hs_aw = AWVALID && AWREADY;
            hs_w  = WVALID && WREADY;
            hs_b  = BVALID && BREADY;
            r     = BRESP;
            if (BVALID) bc++;
            @(posedge clk);
            #1;
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            if ((hs_aw || hs_w) && aw_done && w_done && cc < 0) cc = c;
            if (hs_b) begin
                got  = 1;
                resp = r;
            end
        end
        AWVALID = 0;
        WVALID  = 0;
        BREADY  = 0;
        if (pulse_rdy) tx_ready = 0;
        if (!got) check("b_timeout", 0, 1);
    endtask

    task automatic axi_read(input logic [31:0] a, input int ar_lag,
                            input int r_hold, output logic [31:0] data,
                            output logic [1:0] resp);
        bit ar_done, hs_ar, hs_r, got;
        int rc;
        logic [31:0] dd;
        logic [1:0] rr;
        ar_done = 0;
        got     = 0;
        rc      = 0;
        data    = '1;
        resp    = 2'b11;
        for (int c = 0; c < 64 && !got; c++) begin
            ARADDR  = a;
            ARVALID = !ar_done && c >= ar_lag;
            RREADY  = RVALID && rc >= r_hold;
            #1;
            check("arready", ARREADY, !ar_done);
            if (!ar_done) check("rvalid_early", RVALID, 0);
            else if (rc > 0) check("rvalid_hold", RVALID, 1);
            hs_ar = ARVALID && ARREADY;
            hs_r  = RVALID && RREADY;
            dd    = RDATA;
            rr    = RRESP;
            if (RVALID) rc++;
            @(posedge clk);
            #1;
            if (hs_ar) ar_done = 1;
            if (hs_r) begin
                got  = 1;
                data = dd;
                resp = rr;
            end
        end
        ARVALID = 0;
        RREADY  = 0;
        if (!got) check("r_timeout", 0, 1);
    endtask

    task automatic drain(input int n);
        tx_ready = 1;
        repeat (n) @(posedge clk);
        #1;
        tx_ready = 0;
        check("drained", tx_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  wr, rr;
        logic [31:0] rd;
        logic [31:0] a, d;
        logic [3:0]  s;
        int          sel;
        ARVALID = 0; ARADDR = 0; RREADY = 0;
        AWVALID = 0; AWADDR = 0; WVALID = 0; WDATA = 0; WSTRB = 0;
        BREADY = 0; tx_ready = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", AWREADY, 1);
        check("rst_wready", WREADY, 1);
        check("rst_arready", ARREADY, 1);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_txvalid", tx_valid, 0);
        check("rst_bresp", BRESP, 0);
        check("rst_rresp", RRESP, 0);
        check("rst_rdata", RDATA, 0);
        rst = 0;

        axi_write(32'h0, 32'h41, 4'h1, 0, 0, 0, 0, wr);
        check("t1_bresp", wr, 2'b00);
        check("t1_txvalid", tx_valid, 1);
        check("t1_txbyte", tx_byte, 8'h41);

        axi_write(32'h0, 32'h42, 4'h1, 0, 3, 2, 0, wr);
        check("t2_bresp", wr, 2'b00);
        axi_read(32'h4, 0, 0, rd, rr);
        check("t2_status", rd, 32'h0000_0200);
        check("t2_rresp", rr, 2'b00);
        drain(4);

        for (int i = 0; i < 17; i++) begin
            axi_write(32'h0, $urandom, 4'h1, $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(0, 1), 0, wr);
            check("t3_bresp", wr, (i < 16) ? 2'b00 : 2'b10);
        end
        axi_read(32'h4, 1, 1, rd, rr);
        check("t3_status", rd, 32'h0000_1002);
        drain(20);

        for (int i = 0; i < 16; i++)
            axi_write(32'h0, $urandom, 4'h1, 0, 0, 0, 0, wr);
        axi_write(32'h0, 32'h99, 4'h1, 0, 0, 0, 1, wr);
        check("t4_bresp", wr, 2'b10);
        axi_read(32'h4, 0, 0, rd, rr);
        check("t4_status", rd, 32'h0000_0F00);
        drain(20);

        for (int i = 0; i < 5; i++)
            axi_write(32'h0, $urandom, 4'h1, 0, 0, 0, 0, wr);
        axi_write(32'h8, 32'h1, 4'h1, 0, 0, 0, 0, wr);
        check("t5_bresp", wr, 2'b00);
        check("t5_txvalid", tx_valid, 0);
        axi_read(32'h4, 0, 0, rd, rr);
        check("t5_status", rd, 32'h0000_0001);

        axi_read(32'h0, 0, 0, rd, rr);
        check("t6_rd0_data", rd, 0);
        check("t6_rd0_resp", rr, 2'b10);
        axi_read(32'h8, 0, 0, rd, rr);
        check("t6_rd8_data", rd, 0);
        check("t6_rd8_resp", rr, 2'b00);
        axi_read(32'hC, 0, 0, rd, rr);
        check("t6_rdc_data", rd, 0);
        check("t6_rdc_resp", rr, 2'b10);
        axi_write(32'h4, 32'h1, 4'hF, 0, 0, 0, 0, wr);
        check("t6_wr4_bresp", wr, 2'b10);

        AWADDR  = 32'h0;
        AWVALID = 1;
        @(posedge clk);
        #1;
        AWVALID = 0;
        check("t6_wait_awready", AWREADY, 0);
        check("t6_wait_wready", WREADY, 1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            check("t6_no_bvalid", BVALID, 0);
            @(posedge clk);
            #1;
        end
        check("t6_awready", AWREADY, 1);
        check("t6_wready", WREADY, 1);
        check("t6_bresp_rst", BRESP, 0);
        check("t6_rresp_rst", RRESP, 0);
        axi_write(32'h0, 32'h5A, 4'h1, 2, 0, 0, 0, wr);
        check("t6_after_rst", wr, 2'b00);
        drain(3);

        rnd_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5) a = 32'h0;
            else if (sel == 6) a = 32'h4;
            else if (sel == 7) a = 32'h8;
            else if (sel == 8) a = 32'hC;
            else a = $urandom;
            d = $urandom;
            if (a[3:0] == 4'h8) d[0] = ($urandom_range(0, 3) == 0);
            s = 4'($urandom);
            s[0] = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) == 0) begin
                fork
                    axi_write(a, d, s, $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom_range(0, 2),
                              0, wr);
                    axi_read({28'h0, 2'($urandom), 2'b00},
                             $urandom_range(0, 2), $urandom_range(0, 2),
                             rd, rr);
                join
            end else begin
                axi_write(a, d, s, $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2), 0, wr);
            end
        end
        rnd_rdy = 0;
        @(posedge clk);
        #1;
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
